// File: rtl/egress_framer_if.sv
// Port bundle for egress_framer: crossbar TX byte stream in, GMII transmit stream and status out.
interface egress_framer_if;
    logic [7:0]  tx_data_i;
    logic        tx_ctrl_i;
    logic [7:0]  gmii_txd_o;
    logic        gmii_tx_en_o;
    logic        frame_drop_o;
    logic [15:0] frames_sent_o;

    modport master (
        output tx_data_i, tx_ctrl_i,
        input  gmii_txd_o, gmii_tx_en_o, frame_drop_o, frames_sent_o
    );

    modport slave (
        input  tx_data_i, tx_ctrl_i,
        output gmii_txd_o, gmii_tx_en_o, frame_drop_o, frames_sent_o
    );
endinterface

// File: rtl/egress_framer.sv
// Store-and-forward egress framer: buffers whole frames, then sends preamble/SFD/payload/pad[/FCS]/IFG.
// Define EGRESS_FCS_APPEND_EN to build the CRC-32 generator and append a 4-byte FCS to every frame.
module egress_framer #(
    parameter int P_FIFO_ADDR_WIDTH = 11,
    parameter int P_IFG             = 12,
    parameter int P_MIN_LEN         = 60
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    egress_framer_if.slave  bus
);
    localparam int AW    = P_FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
`ifdef EGRESS_FCS_APPEND_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    typedef logic [AW:0] ptr_t;
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

    entry_t     mem [DEPTH];
    ptr_t       wr_ptr, cmt_ptr, rd_ptr;
    logic [AW:0] frame_cnt;
    logic       stage_vld, discard, drop;
    logic [7:0] stage_data;
    logic       wr_req, wr_last, fifo_full, overflow, commit;

    // The extra pointer bit separates "full" from "empty" when the low bits match.
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_req    = stage_vld;
    assign wr_last   = !bus.tx_ctrl_i;
    assign overflow  = wr_req && fifo_full;
    assign commit    = wr_req && wr_last && !fifo_full;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            stage_vld  <= 1'b0;
            stage_data <= '0;
            discard    <= 1'b0;
            drop       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            drop <= overflow;
            if (overflow) begin
                wr_ptr <= cmt_ptr;
            end else if (wr_req) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_last) cmt_ptr <= wr_ptr + 1'b1;
            end
            if (bus.tx_ctrl_i && !discard && !overflow) begin
                stage_data <= bus.tx_data_i;
                stage_vld  <= 1'b1;
            end else begin
                stage_vld  <= 1'b0;
            end
            discard <= bus.tx_ctrl_i && (discard || overflow);
        end
    end

    // NOTE: the storage array has no reset; pointers and frame_cnt alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_req && !fifo_full) mem[wr_ptr[AW-1:0]] <= '{last: wr_last, data: stage_data};
    end

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] pay_cnt;
    entry_t      rd_q;
    logic        last_sent;
    logic [7:0]  txd;
    logic        tx_en;
    logic [15:0] sent;
    logic        pay_short, data_emit, pad_emit, payload_end, tx_done;

    assign pay_short   = pay_cnt < 16'(P_MIN_LEN);
    assign data_emit   = (state == S_SFD) || (state == S_DATA && !last_sent);
    assign pad_emit    = ((state == S_DATA && last_sent) || state == S_PAD) && pay_short;
    assign payload_end = ((state == S_DATA && last_sent) || state == S_PAD) && !pay_short;
    assign tx_done     = FCS_ON ? (state == S_FCS && cnt == 16'd0) : payload_end;

`ifdef EGRESS_FCS_APPEND_EN
    logic [31:0] crc, fcs_sr;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pay_cnt   <= '0;
            rd_q      <= '0;
            rd_ptr    <= '0;
            last_sent <= 1'b0;
            txd       <= '0;
            tx_en     <= 1'b0;
            sent      <= '0;
`ifdef EGRESS_FCS_APPEND_EN
            crc       <= '1;
            fcs_sr    <= '0;
`endif
        end else begin
            if (data_emit && state == S_SFD)                 pay_cnt <= 16'd1;
            else if ((data_emit || pad_emit) && pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
`ifdef EGRESS_FCS_APPEND_EN
            if (state == S_PREAMBLE) crc <= '1;
            else if (data_emit)      crc <= crc_byte(crc, rd_q.data);
            else if (pad_emit)       crc <= crc_byte(crc, 8'h00);
`endif
            unique case (state)
                S_IDLE: begin
                    if (frame_cnt != '0) begin
                        state <= S_PREAMBLE;
                        tx_en <= 1'b1;
                        txd   <= 8'h55;
                        cnt   <= 16'd6;
                    end
                end
                S_PREAMBLE: begin
                    if (cnt == 16'd0) begin
                        state  <= S_SFD;
                        txd    <= 8'hD5;
                        rd_q   <= mem[rd_ptr[AW-1:0]];
                        rd_ptr <= rd_ptr + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SFD, S_DATA, S_PAD: begin
                    if (data_emit) begin
                        state     <= S_DATA;
                        txd       <= rd_q.data;
                        last_sent <= rd_q.last;
                        if (!rd_q.last) begin
                            rd_q   <= mem[rd_ptr[AW-1:0]];
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end else if (pad_emit) begin
                        state <= S_PAD;
                        txd   <= 8'h00;
                    end else if (tx_done) begin
                        state <= S_IFG;
                        tx_en <= 1'b0;
                        txd   <= 8'h00;
                        cnt   <= 16'(P_IFG - 1);
                        sent  <= sent + 1'b1;
                    end
`ifdef EGRESS_FCS_APPEND_EN
                    else begin
                        state  <= S_FCS;
                        txd    <= ~crc[7:0];
                        fcs_sr <= {8'h00, ~crc[31:8]};
                        cnt    <= 16'd3;
                    end
`endif
                end
`ifdef EGRESS_FCS_APPEND_EN
                S_FCS: begin
                    if (tx_done) begin
                        state <= S_IFG;
                        tx_en <= 1'b0;
                        txd   <= 8'h00;
                        cnt   <= 16'(P_IFG - 1);
                        sent  <= sent + 1'b1;
                    end else begin
                        txd    <= fcs_sr[7:0];
                        fcs_sr <= fcs_sr >> 8;
                        cnt    <= cnt - 1'b1;
                    end
                end
`endif
                S_IFG: begin
                    // A frame already waiting starts straight away so the gap stays exactly P_IFG.
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 1'b1;
                    end else if (frame_cnt != '0) begin
                        state <= S_PREAMBLE;
                        tx_en <= 1'b1;
                        txd   <= 8'h55;
                        cnt   <= 16'd6;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt <= '0;
        end else if (commit && !tx_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end else if (!commit && tx_done) begin
            frame_cnt <= frame_cnt - 1'b1;
        end
    end

    assign bus.gmii_txd_o    = txd;
    assign bus.gmii_tx_en_o  = tx_en;
    assign bus.frame_drop_o  = drop;
    assign bus.frames_sent_o = sent;
endmodule

// File: tb/tb_egress_framer.sv
// Randomized self-checking bench for egress_framer against a byte-stream model of the wire format.
module tb_egress_framer;
    localparam int MIN_LEN = 60;
    localparam int IFG     = 12;
`ifdef EGRESS_FCS_APPEND_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    egress_framer_if bus ();

    egress_framer #(
        .P_FIFO_ADDR_WIDTH (6),
        .P_IFG             (IFG),
        .P_MIN_LEN         (MIN_LEN)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_bytes [$];
    int         exp_lens  [$];
    logic [7:0] pl [$];
    int pushed = 0, started = 0, exp_drops = 0, drops_seen = 0;
    int run_len = 0, low_cnt = 0, last_gap = 0, last_len = 0;
    logic [7:0]  last_byte = 8'h00;
    logic        prev_en = 1'b0;
    logic [31:0] crc_run = '1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // Model: wire image = 7x55, D5, payload, zero pad up to MIN_LEN, optional FCS LSB first.
    task automatic model_push();
        logic [31:0] c;
        int n;
        c = '1;
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        for (int i = 0; i < pl.size(); i++) begin
            exp_bytes.push_back(pl[i]);
            c = crc_step(c, pl[i]);
        end
        n = pl.size();
        while (n < MIN_LEN) begin
            exp_bytes.push_back(8'h00);
            c = crc_step(c, 8'h00);
            n++;
        end
        c = ~c;
        for (int i = 0; i < FCS_BYTES; i++) exp_bytes.push_back(c[8*i +: 8]);
        exp_lens.push_back(8 + n + FCS_BYTES);
        pushed++;
    endtask

    task automatic drive_frame(input bit dropped, input int gap);
        for (int i = 0; i < pl.size(); i++) begin
            bus.tx_data_i = pl[i];
            bus.tx_ctrl_i = 1'b1;
            @(posedge clk); #1;
        end
        bus.tx_ctrl_i = 1'b0;
        bus.tx_data_i = 8'h00;
        if (dropped) exp_drops++;
        else         model_push();
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while ((exp_bytes.size() != 0 || quiet < 20) && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (bus.gmii_tx_en_o) quiet = 0;
            else                  quiet++;
        end
        check("idle_timeout", 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_pending();
        int n = 0;
        while (pushed - started > 1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("pending_timeout", 32'(n < 5000), 32'd1);
    endtask

    // Compare process: every transmitted byte, every frame length, drop pulses.
    always @(negedge clk) begin
        logic [8:0] exp9;
        int exp_len;
        if (!rstn) begin
            prev_en = 1'b0;
            run_len = 0;
            low_cnt = 0;
        end else begin
            if (bus.frame_drop_o) drops_seen++;
            if (bus.gmii_tx_en_o) begin
                if (!prev_en) begin
                    last_gap = low_cnt;
                    started++;
                    run_len = 0;
                    crc_run = '1;
                end
                exp9 = (exp_bytes.size() != 0) ? {1'b0, exp_bytes.pop_front()} : 9'h100;
                check("txd", {23'd0, 1'b0, bus.gmii_txd_o}, {23'd0, exp9});
                run_len++;
                last_byte = bus.gmii_txd_o;
                if (run_len > 8) crc_run = crc_step(crc_run, bus.gmii_txd_o);
                low_cnt = 0;
            end else begin
                if (prev_en) begin
                    exp_len = (exp_lens.size() != 0) ? exp_lens.pop_front() : -1;
                    check("frame_len", 32'(run_len), 32'(exp_len));
                    last_len = run_len;
`ifdef EGRESS_FCS_APPEND_EN
                    check("fcs_residue", {<<{crc_run}}, 32'hC704_DD7B);
`endif
                end
                low_cnt++;
            end
            prev_en = bus.gmii_tx_en_o;
        end
    end

    initial begin
        int len, hi, n;
        bit dropped;
        bus.tx_ctrl_i = 1'b0;
        bus.tx_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", {24'd0, bus.gmii_txd_o}, 32'h0);
        check("rst_en", {31'd0, bus.gmii_tx_en_o}, 32'h0);
        check("rst_drop", {31'd0, bus.frame_drop_o}, 32'h0);
        check("rst_sent", {16'd0, bus.frames_sent_o}, 32'h0);
        rstn = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_en", {31'd0, bus.gmii_tx_en_o}, 32'h0);

        // 64-byte frame 0x00..0x3F, with commit-to-first-preamble latency.
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        drive_frame(1'b0, 0);
        @(posedge clk); #1;
        check("lat_before", {31'd0, bus.gmii_tx_en_o}, 32'h0);
        @(posedge clk); #1;
        check("lat_rise", {31'd0, bus.gmii_tx_en_o}, 32'h1);
        check("lat_first", {24'd0, bus.gmii_txd_o}, 32'h55);
        wait_idle();
        check("f64_len", 32'(last_len), 32'(72 + FCS_BYTES));
        if (FCS_BYTES == 0) check("f64_last", {24'd0, last_byte}, 32'h3F);
        check("f64_sent", {16'd0, bus.frames_sent_o}, 32'd1);

        // Short frame padded to MIN_LEN.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'hAA + 8'(i));
        drive_frame(1'b0, 1);
        wait_idle();
        check("short_len", 32'(last_len), 32'(68 + FCS_BYTES));
        check("short_sent", {16'd0, bus.frames_sent_o}, 32'd2);

        // Back-to-back 8-byte frames, 1 idle input cycle apart.
        for (int f = 0; f < 2; f++) begin
            pl.delete();
            for (int i = 0; i < 8; i++) pl.push_back(8'(16 * f + i + 1));
            drive_frame(1'b0, 1);
        end
        wait_idle();
        check("b2b_gap", 32'(last_gap), 32'd12);
        check("b2b_sent", {16'd0, bus.frames_sent_o}, 32'd4);

        // Overflow: 100-byte frame into a 64-entry FIFO, then an 8-byte frame.
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i + 7));
        drive_frame(1'b1, 1);
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'hC0 + 8'(i));
        drive_frame(1'b0, 1);
        wait_idle();
        check("ovf_drops", 32'(drops_seen), 32'd1);
        check("ovf_sent", {16'd0, bus.frames_sent_o}, 32'd5);

        // Random frames; occupancy kept within the FIFO except deliberate oversize drops.
        for (int f = 0; f < 24; f++) begin
            if (f % 8 == 7) begin
                wait_idle();
                len = $urandom_range(65, 90);
                dropped = 1'b1;
            end else begin
                wait_pending();
                len = $urandom_range(1, 20);
                dropped = 1'b0;
            end
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            drive_frame(dropped, $urandom_range(1, 6));
        end
        wait_idle();
        check("rand_sent", {16'd0, bus.frames_sent_o}, 32'(pushed));
        check("rand_drops", 32'(drops_seen), 32'(exp_drops));

        // Reset during DATA of a 64-byte frame.
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
        drive_frame(1'b0, 1);
        n = 0;
        while (!bus.gmii_tx_en_o && n < 500) begin @(posedge clk); #1; n++; end
        check("rst_mid_start", 32'(n < 500), 32'd1);
        repeat (20) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        check("rst_mid_en", {31'd0, bus.gmii_tx_en_o}, 32'h0);
        check("rst_mid_txd", {24'd0, bus.gmii_txd_o}, 32'h0);
        check("rst_mid_sent", {16'd0, bus.frames_sent_o}, 32'h0);
        exp_bytes.delete();
        exp_lens.delete();
        pushed = 0;
        started = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        hi = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (bus.gmii_tx_en_o) hi++;
        end
        check("post_rst_quiet", 32'(hi), 32'd0);
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        drive_frame(1'b0, 1);
        wait_idle();
        check("post_rst_sent", {16'd0, bus.frames_sent_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
